// File: rtl/tdm_slot_sequencer_pkg.sv
// Shared definitions for the TDM slot sequencer.
//   state_t    : frame-alignment state (HUNT searching for SOF, LOCK aligned)
//   addr_width : slot-index width for a given slot count (at least 1 bit)
package tdm_slot_sequencer_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

   function automatic int addr_width(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

endpackage

// File: rtl/tdm_slot_sequencer_stream_reg.sv
// Single-entry valid/ready output register carrying a word plus its slot index.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : capture data_i/addr_i this cycle (caller guarantees room)
//   data_i       : word to capture
//   addr_i       : slot index to capture
//   out_ready_i  : downstream consumes when out_valid_o is high
//   out_valid_o  : register holds a word
//   out_data_o   : held word
//   out_addr_o   : held slot index
module tdm_slot_sequencer_stream_reg #(
   parameter int DWIDTH = 3,
   parameter int AW     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic [AW-1:0]     addr_i,
   input  logic              out_ready_i,
   output logic              out_valid_o,
   output logic [DWIDTH-1:0] out_data_o,
   output logic [AW-1:0]     out_addr_o
);

   logic              valid_q;
   logic [DWIDTH-1:0] data_q;
   logic [AW-1:0]     addr_q;

   // A load wins over a consume, so a simultaneous consume+load keeps valid high
   // with the new word; without a load the payload is held untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         addr_q  <= addr_i;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign out_addr_o  = addr_q;

endmodule

// File: rtl/tdm_slot_sequencer.sv
// TDM slot sequencer: tracks frame alignment of a word stream using a
// start-of-frame marker, tags each word with its slot index and presents it as
// a registered valid/ready stream for the channel demultiplexor.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : TDM word
//   in_sof     : word is slot 0 of a frame
//   in_valid   : input word present
//   in_ready   : input word accepted when in_valid && in_ready
//   out_data   : registered word (demultiplexor in)
//   out_addr   : registered slot index (demultiplexor addr)
//   out_valid  : output word present
//   out_ready  : downstream consumes when out_valid && out_ready
//   locked     : registered, high while in LOCK
//   sync_err   : registered one-cycle pulse per alignment error
//   frame_cnt  : completed frames, wraps modulo 2^FCNT_W
module tdm_slot_sequencer
   import tdm_slot_sequencer_pkg::*;
#(
   parameter int DWIDTH      = 3,
   parameter int CH_NUM      = 2,
   parameter bit REQUIRE_SOF = 1'b1,
   parameter int FCNT_W      = 16,
   localparam int AW         = addr_width(CH_NUM)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] in_data,
   input  logic              in_sof,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic [AW-1:0]     out_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              locked,
   output logic              sync_err,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam logic [AW-1:0]     SLOT_ONE  = AW'(1);
   localparam logic [AW-1:0]     SLOT_LAST = AW'(CH_NUM - 1);
   localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

   state_t            state_q, state_d;
   logic [AW-1:0]     slot_q, slot_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              err_q, err_d;
   logic              locked_q;

   logic              accept;
   logic              load;
   logic [AW-1:0]     load_addr;

   assign accept = in_valid && in_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic, including slot/frame bookkeeping and load decisions
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      fcnt_d    = fcnt_q;
      err_d     = 1'b0;
      load      = 1'b0;
      load_addr = '0;
      unique case (state_q)
         HUNT: begin
            // Non-SOF words are discarded while searching for alignment.
            if (accept && in_sof) begin
               load    = 1'b1;
               slot_d  = SLOT_ONE;
               state_d = LOCK;
            end
         end
         LOCK: begin
            if (accept) begin
               if (in_sof && (slot_q != '0)) begin
                  // Early SOF: realign on this word, the short frame is not counted.
                  err_d  = 1'b1;
                  load   = 1'b1;
                  slot_d = SLOT_ONE;
               end else if (REQUIRE_SOF && !in_sof && (slot_q == '0)) begin
                  // Missing SOF: drop the word but leave any pending output to drain.
                  err_d   = 1'b1;
                  state_d = HUNT;
               end else begin
                  load      = 1'b1;
                  load_addr = slot_q;
                  if (slot_q == SLOT_LAST) begin
                     slot_d = '0;
                     fcnt_d = fcnt_q + FCNT_ONE;
                  end else begin
                     slot_d = slot_q + SLOT_ONE;
                  end
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // Output logic: HUNT always accepts (it only discards or loads a frame start);
   // LOCK accepts only when the output register can take a word this cycle.
   always_comb begin
      in_ready = 1'b1;
      if (state_q == LOCK) begin
         in_ready = !out_valid || out_ready;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q   <= '0;
         fcnt_q   <= '0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         slot_q   <= slot_d;
         fcnt_q   <= fcnt_d;
         err_q    <= err_d;
         locked_q <= (state_d == LOCK);
      end
   end

   tdm_slot_sequencer_stream_reg #(
      .DWIDTH (DWIDTH),
      .AW     (AW)
   ) u_stream_reg (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load),
      .data_i      (in_data),
      .addr_i      (load_addr),
      .out_ready_i (out_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_addr_o  (out_addr)
   );

   assign locked    = locked_q;
   assign sync_err  = err_q;
   assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_tdm_slot_sequencer.sv
module tb_tdm_slot_sequencer;

   localparam int DW = 3;
   localparam int CH = 4;
   localparam int FW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic          in_sof = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic [1:0]    out_addr;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          locked;
   logic          sync_err;
   logic [FW-1:0] frame_cnt;

   tdm_slot_sequencer #(
      .DWIDTH      (DW),
      .CH_NUM      (CH),
      .REQUIRE_SOF (1'b1),
      .FCNT_W      (FW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sof    (in_sof),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .locked    (locked),
      .sync_err  (sync_err),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          sof;
      logic          load;
      logic [1:0]    addr;
      logic          lock_after;
      logic          err_after;
      logic [FW-1:0] fcnt_after;
   } vec_t;

   int checks = 0;
   int failures = 0;
   logic [4:0] sb[$];
   vec_t tbl[$];

   function automatic vec_t mk(input logic [DW-1:0] d, input logic s, input logic ld,
                               input logic [1:0] a, input logic lk, input logic e,
                               input logic [FW-1:0] f);
      vec_t v;
      v.data = d; v.sof = s; v.load = ld; v.addr = a;
      v.lock_after = lk; v.err_after = e; v.fcnt_after = f;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one word, wait (bounded) for acceptance, queue its expected output,
   // then check the registered status after the accepting edge.
   task automatic apply_vec(input vec_t v, input string tag);
      bit got = 0;
      in_valid = 1'b1;
      in_data  = v.data;
      in_sof   = v.sof;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (in_ready) got = 1;
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s accept_timeout: in_ready stayed 0, required 1", tag);
         return;
      end
      if (v.load) sb.push_back({v.data, v.addr});
      @(posedge clk);
      #1;
      check({tag, " locked"}, locked, v.lock_after);
      check({tag, " sync_err"}, sync_err, v.err_after);
      check({tag, " frame_cnt"}, frame_cnt, v.fcnt_after);
   endtask

   // Scoreboard: every handshake on the output is compared with the queue head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected: got data=%0d addr=%0d, required no output",
                     out_data, out_addr);
         end else begin
            logic [4:0] e;
            e = sb.pop_front();
            if ({out_data, out_addr} != e) begin
               failures++;
               $display("FAIL out_word: got data=%0d addr=%0d, required data=%0d addr=%0d",
                        out_data, out_addr, e[4:2], e[1:0]);
            end
         end
      end
   end

   initial begin
      // Reset state
      #2;
      check("rst out_valid", out_valid, 0);
      check("rst out_data", out_data, 0);
      check("rst out_addr", out_addr, 0);
      check("rst locked", locked, 0);
      check("rst sync_err", sync_err, 0);
      check("rst frame_cnt", frame_cnt, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle in_ready", in_ready, 1);
      check("idle locked", locked, 0);
      check("idle out_valid", out_valid, 0);
      @(posedge clk); #1;
      out_ready = 1'b1;

      // Hunt and lock, early SOF, missing SOF, relock
      tbl.push_back(mk(3'd5, 0, 0, 2'd0, 0, 0, 2'd0));
      tbl.push_back(mk(3'd6, 0, 0, 2'd0, 0, 0, 2'd0));
      tbl.push_back(mk(3'd1, 1, 1, 2'd0, 1, 0, 2'd0));
      tbl.push_back(mk(3'd2, 0, 1, 2'd1, 1, 0, 2'd0));
      tbl.push_back(mk(3'd3, 0, 1, 2'd2, 1, 0, 2'd0));
      tbl.push_back(mk(3'd4, 0, 1, 2'd3, 1, 0, 2'd1));
      tbl.push_back(mk(3'd1, 1, 1, 2'd0, 1, 0, 2'd1));
      tbl.push_back(mk(3'd2, 0, 1, 2'd1, 1, 0, 2'd1));
      tbl.push_back(mk(3'd7, 1, 1, 2'd0, 1, 1, 2'd1));
      tbl.push_back(mk(3'd3, 0, 1, 2'd1, 1, 0, 2'd1));
      tbl.push_back(mk(3'd4, 0, 1, 2'd2, 1, 0, 2'd1));
      tbl.push_back(mk(3'd5, 0, 1, 2'd3, 1, 0, 2'd2));
      tbl.push_back(mk(3'd6, 0, 0, 2'd0, 0, 1, 2'd2));
      tbl.push_back(mk(3'd1, 0, 0, 2'd0, 0, 0, 2'd2));
      tbl.push_back(mk(3'd1, 1, 1, 2'd0, 1, 0, 2'd2));
      tbl.push_back(mk(3'd2, 0, 1, 2'd1, 1, 0, 2'd2));
      tbl.push_back(mk(3'd3, 0, 1, 2'd2, 1, 0, 2'd2));
      tbl.push_back(mk(3'd4, 0, 1, 2'd3, 1, 0, 2'd3));
      for (int i = 0; i < tbl.size(); i++) begin
         apply_vec(tbl[i], $sformatf("tbl[%0d]", i));
      end

      // Backpressure mid-frame
      apply_vec(mk(3'd5, 1, 1, 2'd0, 1, 0, 2'd3), "bp0");
      apply_vec(mk(3'd6, 0, 1, 2'd1, 1, 0, 2'd3), "bp1");
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 3'd7;
      in_sof    = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp in_ready", in_ready, 0);
         check("bp out_valid", out_valid, 1);
         check("bp out_data", out_data, 6);
         check("bp out_addr", out_addr, 1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      apply_vec(mk(3'd7, 0, 1, 2'd2, 1, 0, 2'd3), "bp2");
      apply_vec(mk(3'd1, 0, 1, 2'd3, 1, 0, 2'd0), "bp3");

      // Five full frames: frame_cnt 1,2,3,0,1
      for (int f = 0; f < 5; f++) begin
         for (int s = 0; s < 4; s++) begin
            logic [FW-1:0] fe;
            logic [DW-1:0] d;
            fe = (s == 3) ? FW'((f + 1) % 4) : FW'(f % 4);
            d  = DW'((f + s + 1) % 8);
            apply_vec(mk(d, (s == 0), 1, 2'(s), 1, 0, fe), $sformatf("wrap f%0d s%0d", f, s));
         end
      end

      // Asynchronous reset mid-frame with a pending word
      apply_vec(mk(3'd2, 1, 1, 2'd0, 1, 0, 2'd1), "ar0");
      apply_vec(mk(3'd3, 0, 1, 2'd1, 1, 0, 2'd1), "ar1");
      out_ready = 1'b0;
      in_valid  = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst out_valid", out_valid, 0);
      check("arst out_data", out_data, 0);
      check("arst out_addr", out_addr, 0);
      check("arst locked", locked, 0);
      check("arst frame_cnt", frame_cnt, 0);
      check("arst sync_err", sync_err, 0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      apply_vec(mk(3'd4, 0, 0, 2'd0, 0, 0, 2'd0), "relock0");
      apply_vec(mk(3'd1, 1, 1, 2'd0, 1, 0, 2'd0), "relock1");
      apply_vec(mk(3'd2, 0, 1, 2'd1, 1, 0, 2'd0), "relock2");
      apply_vec(mk(3'd3, 0, 1, 2'd2, 1, 0, 2'd0), "relock3");
      apply_vec(mk(3'd4, 0, 1, 2'd3, 1, 0, 2'd1), "relock4");
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("scoreboard drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tdm_slot_sequencer.md
# tdm_slot_sequencer

Upstream control stage for the channel demultiplexor. It accepts a time-division-multiplexed word stream with a start-of-frame marker and tracks frame alignment. Each word is tagged with its slot index, and the word plus index are presented as a registered valid/ready stream whose data and address drive the demultiplexor's `in` and `addr` directly. The block also reports lock state, alignment errors and a completed-frame count.

## Interface
- `DWIDTH`, 3, word width; matches demultiplexor `DWIDTH`.
- `CH_NUM`, 2, slots per frame; must be ≥ 2.
- `REQUIRE_SOF`, 1, if 1 a slot-0 word without `in_sof` is an alignment error.
- `FCNT_W`, 16, width of the frame counter.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  DWIDTH  TDM word.
- `in_sof`  in  1  marks the word as slot 0 of a frame.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  input word accepted when `in_valid && in_ready`.
- `out_data`  out  DWIDTH  registered word, to demultiplexor `in`.
- `out_addr`  out  $clog2(CH_NUM)  slot index, to demultiplexor `addr`.
- `out_valid`  out  1  output word present.
- `out_ready`  in  1  downstream consumes when `out_valid && out_ready`.
- `locked`  out  1  high in LOCK state.
- `sync_err`  out  1  one-cycle pulse per alignment error.
- `frame_cnt`  out  FCNT_W  completed frames; wraps modulo 2^FCNT_W.

## Operation
States are HUNT and LOCK. A word is accepted on cycles where `in_valid && in_ready`; `slot_cnt` is an internal counter in 0..CH_NUM-1.

HUNT:
- `in_ready` = 1; every accepted word without `in_sof` is dropped silently.
- An accepted word with `in_sof`:
  - loads the output register with addr 0;
  - sets `slot_cnt` = 1;
  - moves the state to LOCK.

LOCK:
- `in_ready` = `!out_valid || out_ready`.
- Normal accept: the word is loaded with addr = `slot_cnt`, then `slot_cnt` increments.
- Accepting slot CH_NUM-1 wraps `slot_cnt` to 0 and increments `frame_cnt`.
- `in_sof` with `slot_cnt` ≠ 0 (early SOF):
  - pulse `sync_err`;
  - treat the word as slot 0: load with addr 0, set `slot_cnt` = 1;
  - stay in LOCK;
  - `frame_cnt` does not increment.
- `slot_cnt` = 0 without `in_sof` (missing SOF):
  - if `REQUIRE_SOF` = 1: pulse `sync_err`, drop the word, go to HUNT; the output register is untouched, so a pending word still drains.
  - if `REQUIRE_SOF` = 0: accept normally as slot 0.

Output register:
- `out_valid` sets on load.
- `out_valid` clears on `out_ready` when there is no simultaneous load.
- Simultaneous consume and load: the register takes the new word and `out_valid` stays 1.
- `out_data` and `out_addr` are held stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - state HUNT;
  - `slot_cnt` 0, `frame_cnt` 0;
  - `out_valid` 0, `out_data` 0, `out_addr` 0;
  - `locked` 0, `sync_err` 0.
- The asynchronous reset mid-frame takes effect immediately and discards any pending output word.
- Latency: an input accepted at edge N is visible on the outputs after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle while `out_ready` stays high.
- `in_ready` in LOCK is combinational from `out_valid`/`out_ready`; there is no combinational path from `in_valid` to `in_ready`.
- `sync_err` is registered and high exactly in the cycle after the offending accept.
- `frame_cnt` updates on the edge that accepts the last slot.
- `locked` is registered and equals (state == LOCK).

## Structure
- Shared package holds the state typedef (`HUNT`, `LOCK`) and a helper constant for the address width, $clog2(CH_NUM).
- Natural sub-module: `stream_reg`, the single-entry valid/ready output register (DWIDTH + address payload).
- Everything else (state machine, slot and frame counters) lives in the top module.

## Test plan
All scenarios use `CH_NUM` = 4.
- Reset, then idle: all outputs 0; after `rst` deassert `in_ready` = 1 and `locked` = 0.
- Hunt and lock: send words 5,6 without SOF, then SOF-framed 1,2,3,4 with `out_ready` = 1 → 5,6 dropped; outputs (1,0),(2,1),(3,2),(4,3); `frame_cnt` = 1; `locked` = 1 from the cycle after word 1.
- Backpressure: hold `out_ready` = 0 for 3 cycles mid-frame → `in_ready` = 0; `out_data`/`out_addr` stable; no loss or duplication after release.
- Early SOF: SOF arrives at slot 2 → one `sync_err` pulse; that word is output with addr 0; the next word gets addr 1; `frame_cnt` unchanged.
- Missing SOF (`REQUIRE_SOF` = 1): a word at slot 0 without SOF → `sync_err` pulse; word dropped; `locked` = 0 next cycle; the pending output word still delivered.
- Counter wrap: `FCNT_W` = 2, stream 5 full frames → `frame_cnt` sequence 1,2,3,0,1.
- Async reset asserted mid-frame → outputs return to reset values; the next frame requires SOF to relock.
